// File: rtl/seq_restoring_divider_if.sv
// rtl/seq_restoring_divider_if.sv - command/result handshake bundle for seq_restoring_divider
interface seq_restoring_divider_if #(
    parameter int WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef SEQ_DIV_SIGNED_EN
    logic             op_signed;
`endif
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    // Issuer side: presents operands and consumes results.
    modport master (
`ifdef SEQ_DIV_SIGNED_EN
        output op_signed,
`endif
        output cmd_valid, dividend, divisor, res_ready,
        input  cmd_ready, res_valid, quotient, remainder, div_by_zero, busy
    );

    // Divider side.
    modport slave (
`ifdef SEQ_DIV_SIGNED_EN
        input  op_signed,
`endif
        input  cmd_valid, dividend, divisor, res_ready,
        output cmd_ready, res_valid, quotient, remainder, div_by_zero, busy
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - radix-2 restoring divider, one quotient bit per cycle; SEQ_DIV_SIGNED_EN adds signed mode
module seq_restoring_divider #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    seq_restoring_divider_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic             neg_q;
    logic             neg_r;

    logic             cmd_ready_r;
    logic             res_valid_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             div_by_zero_r;
    logic             busy_r;

    assign bus.cmd_ready   = cmd_ready_r;
    assign bus.res_valid   = res_valid_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = div_by_zero_r;
    assign bus.busy        = busy_r;

    // Operand magnitudes and result sign flags captured on accept.
    logic [WIDTH-1:0] dd_mag;
    logic [WIDTH-1:0] dv_mag;
    logic             dd_neg;
    logic             dv_neg;

`ifdef SEQ_DIV_SIGNED_EN
    assign dd_neg = bus.op_signed & bus.dividend[WIDTH-1];
    assign dv_neg = bus.op_signed & bus.divisor[WIDTH-1];
`else
    assign dd_neg = 1'b0;
    assign dv_neg = 1'b0;
`endif
    assign dd_mag = dd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    assign dv_mag = dv_neg ? (~bus.divisor + 1'b1)  : bus.divisor;

    // Trial subtraction one bit wider than the shifted remainder so the top bit is the borrow.
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_quo;
    logic [WIDTH-1:0] fin_quo;
    logic [WIDTH-1:0] fin_rem;

    // One restoring step plus the sign fix-up applied when the last step lands in DONE.
    always_comb begin
        diff     = {1'b0, rem_r, quo_r[WIDTH-1]} - {2'b00, dvs_r};
        borrow   = diff[WIDTH+1];
        next_rem = borrow ? {rem_r[WIDTH-2:0], quo_r[WIDTH-1]} : diff[WIDTH-1:0];
        next_quo = {quo_r[WIDTH-2:0], ~borrow};
        fin_quo  = neg_q ? (~next_quo + 1'b1) : next_quo;
        fin_rem  = neg_r ? (~next_rem + 1'b1) : next_rem;
    end

    // Control FSM with all handshake outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            rem_r         <= '0;
            quo_r         <= '0;
            dvs_r         <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            cmd_ready_r   <= 1'b0;
            res_valid_r   <= 1'b0;
            quotient_r    <= '0;
            remainder_r   <= '0;
            div_by_zero_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready_r <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_r) begin
                        cmd_ready_r <= 1'b0;
                        if (bus.divisor == '0) begin
                            state         <= DONE;
                            res_valid_r   <= 1'b1;
                            quotient_r    <= '1;
                            remainder_r   <= bus.dividend;
                            div_by_zero_r <= 1'b1;
                        end else begin
                            state         <= BUSY;
                            busy_r        <= 1'b1;
                            cnt           <= CW'(WIDTH - 1);
                            rem_r         <= '0;
                            quo_r         <= dd_mag;
                            dvs_r         <= dv_mag;
                            neg_q         <= dd_neg ^ dv_neg;
                            neg_r         <= dd_neg;
                            div_by_zero_r <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    rem_r <= next_rem;
                    quo_r <= next_quo;
                    if (cnt == '0) begin
                        state       <= DONE;
                        busy_r      <= 1'b0;
                        res_valid_r <= 1'b1;
                        quotient_r  <= fin_quo;
                        remainder_r <= fin_rem;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state       <= IDLE;
                        res_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    busy_r      <= 1'b0;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
